ram_port_arbiter: RTL and testbench



---
 rtl/ram_port_arbiter.sv | 128 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter in front of a single-port RAM with a one-cycle response path.
// Define RAM_ARB_RR_EN for round-robin contention handling; otherwise m0 has fixed priority.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_i,

    input  logic                  m0_req_i,
    output logic                  m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [BE_WIDTH-1:0]   m0_be_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_req_i,
    output logic                  m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [BE_WIDTH-1:0]   m1_be_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,

    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [BE_WIDTH-1:0]   ram_be_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    logic [1:0]            req;
    logic [1:0]            gnt;
    logic                  sel;
    logic                  any_gnt;
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic                  we    [2];
    logic [BE_WIDTH-1:0]   be    [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [1:0]            rvalid;
    logic [DATA_WIDTH-1:0] rdata [2];

    logic                  resp_valid_reg;
    logic                  resp_owner_reg;

    assign req      = {m1_req_i, m0_req_i};
    assign addr[0]  = m0_addr_i;
    assign addr[1]  = m1_addr_i;
    assign we[0]    = m0_we_i;
    assign we[1]    = m1_we_i;
    assign be[0]    = m0_be_i;
    assign be[1]    = m1_be_i;
    assign wdata[0] = m0_wdata_i;
    assign wdata[1] = m1_wdata_i;

`ifdef RAM_ARB_RR_EN
    logic prio_reg;

    always_comb begin
        gnt = 2'b00;
        if (!rst_i) begin
            if (req == 2'b11) begin
                gnt[prio_reg] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    // Preferred master flips to the other one after every accepted access.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            prio_reg <= 1'b0;
        end else if (any_gnt) begin
            prio_reg <= ~sel;
        end
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (!rst_i) begin
            gnt = (req == 2'b11) ? 2'b01 : req;
        end
    end
`endif

    assign sel      = gnt[1];
    assign any_gnt  = |gnt;
    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];

    assign ram_en_o    = any_gnt;
    assign ram_addr_o  = any_gnt ? addr[sel]  : '0;
    assign ram_we_o    = any_gnt ? we[sel]    : 1'b0;
    assign ram_be_o    = any_gnt ? be[sel]    : '0;
    assign ram_wdata_o = any_gnt ? wdata[sel] : '0;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            resp_valid_reg <= 1'b0;
            resp_owner_reg <= 1'b0;
        end else begin
            resp_valid_reg <= any_gnt;
            if (any_gnt) begin
                resp_owner_reg <= sel;
            end
        end
    end

    // Responses are suppressed while reset is held so a pending reply is dropped.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign rvalid[gi] = resp_valid_reg && !rst_i && (resp_owner_reg == 1'(gi));
            assign rdata[gi]  = rvalid[gi] ? ram_rdata_i : '0;
        end
    endgenerate

    assign m0_rvalid_o = rvalid[0];
    assign m1_rvalid_o = rvalid[1];
    assign m0_rdata_o  = rdata[0];
    assign m1_rdata_o  = rdata[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic against a reference
// model of arbitration and RAM contents; expected responses flow through a scoreboard queue.
module tb_ram_port_arbiter;
    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int WORDS = 1 << (AW - 2);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]    req;
    logic [AW-1:0] addr  [2];
    logic          we    [2];
    logic [BW-1:0] be    [2];
    logic [DW-1:0] wdata [2];
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata [2];

    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [BW-1:0] ram_be;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_i(rst),
        .m0_req_i(req[0]), .m0_gnt_o(gnt[0]), .m0_addr_i(addr[0]), .m0_we_i(we[0]),
        .m0_be_i(be[0]), .m0_wdata_i(wdata[0]), .m0_rvalid_o(rvalid[0]), .m0_rdata_o(rdata[0]),
        .m1_req_i(req[1]), .m1_gnt_o(gnt[1]), .m1_addr_i(addr[1]), .m1_we_i(we[1]),
        .m1_be_i(be[1]), .m1_wdata_i(wdata[1]), .m1_rvalid_o(rvalid[1]), .m1_rdata_o(rdata[1]),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    // Behavioural single-port RAM attached to the arbiter.
    logic [DW-1:0] ram_mem [WORDS];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= ram_mem[ram_addr[AW-1:2]];
            if (ram_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (ram_be[b]) ram_mem[ram_addr[AW-1:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    typedef struct {
        int          stamp;
        bit          owner;
        bit          wr;
        logic [DW-1:0] data;
    } resp_t;

    resp_t         sb [$];
    logic [DW-1:0] ref_mem [WORDS];
    bit            prio_m = 1'b0;
    logic [1:0]    granted = 2'b00;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: decides the grant from the request rules and records the expected reply.
    always @(negedge clk) begin : model
        logic [1:0] exp_g;
        int w;
        int wi;
        resp_t e;
        exp_g = 2'b00;
        if (rst) begin
            prio_m = 1'b0;
            while (sb.size() > 0 && sb[0].stamp < cyc) void'(sb.pop_front());
        end else if (req == 2'b11) begin
`ifdef RAM_ARB_RR_EN
            exp_g = prio_m ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
        end else begin
            exp_g = req;
        end
        chk("gnt", {62'd0, gnt}, {62'd0, exp_g});
        granted = exp_g;
        if (exp_g != 2'b00) begin
            w  = exp_g[1] ? 1 : 0;
            wi = int'(addr[w][AW-1:2]);
            chk("ram_port", {11'd0, ram_en, ram_addr, ram_we, ram_be, ram_wdata},
                {11'd0, 1'b1, addr[w], we[w], be[w], wdata[w]});
            e.stamp = cyc;
            e.owner = w[0];
            e.wr    = we[w];
            e.data  = ref_mem[wi];
            sb.push_back(e);
            if (we[w]) begin
                for (int b = 0; b < BW; b++) begin
                    if (be[w][b]) ref_mem[wi][8*b +: 8] = wdata[w][8*b +: 8];
                end
            end
            prio_m = ~w[0];
        end else begin
            chk("ram_idle", {11'd0, ram_en, ram_addr, ram_we, ram_be, ram_wdata}, 64'd0);
        end
    end

    // Monitor: consumes the scoreboard whenever a response is presented.
    always @(negedge clk) begin : monitor
        resp_t e;
        if (rvalid != 2'b00) begin
            if (rst) begin
                chk("rvalid_in_reset", {62'd0, rvalid}, 64'd0);
            end else if (rvalid == 2'b11) begin
                chk("rvalid_both", {62'd0, rvalid}, 64'd1);
            end else if (sb.size() == 0 || sb[0].stamp != cyc - 1) begin
                chk("rvalid_unexpected", {62'd0, rvalid}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rvalid_owner", {63'd0, rvalid[1]}, {63'd0, e.owner});
                if (!e.wr) chk("rdata", {32'd0, rdata[e.owner]}, {32'd0, e.data});
                chk("rdata_other", {32'd0, rdata[~e.owner]}, 64'd0);
                $display("resp cyc=%0d owner=m%0d %s data=%h", cyc, e.owner, e.wr ? "wr" : "rd",
                         rdata[e.owner]);
            end
        end else begin
            chk("rdata_gated", {rdata[1], rdata[0]}, 64'd0);
            if (!rst && sb.size() > 0 && sb[0].stamp < cyc) begin
                chk("rvalid_missing", 64'd0, 64'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(int m, bit r, logic [AW-1:0] a, bit w, logic [BW-1:0] b, logic [DW-1:0] d);
        req[m]   = r;
        addr[m]  = a;
        we[m]    = w;
        be[m]    = b;
        wdata[m] = d;
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ram_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;

        rst = 1'b1;
        set_m(0, 1, 15'h0010, 0, 4'hF, 0);
        set_m(1, 0, 15'h0000, 0, 4'h0, 0);
        step(); step(); step();
        rst = 1'b0;

        // Single read from m0
        set_m(0, 1, 15'h0010, 0, 4'hF, 0);
        step();
        set_m(0, 0, 15'h0000, 0, 4'h0, 0);
        step(); step();

        // m1 full write, read back, partial write, read back
        set_m(1, 1, 15'h0100, 1, 4'hF, 32'hA5A5_A5A5); step();
        set_m(1, 1, 15'h0100, 0, 4'hF, 0);             step();
        set_m(1, 1, 15'h0100, 1, 4'h1, 32'h0000_00FF); step();
        set_m(1, 1, 15'h0100, 0, 4'hF, 0);             step();
        set_m(1, 0, 15'h0000, 0, 4'h0, 0);             step(); step();

        // Contention from reset for four cycles, then m0 drops
        rst = 1'b1; step(); rst = 1'b0;
        set_m(0, 1, 15'h0020, 0, 4'hF, 0);
        set_m(1, 1, 15'h0024, 0, 4'hF, 0);
        step(); step(); step(); step();
        set_m(0, 0, 15'h0000, 0, 4'h0, 0); step();
        set_m(1, 0, 15'h0000, 0, 4'h0, 0); step(); step();

        // Back-to-back uncontested reads
        for (int i = 0; i < 8; i++) begin
            set_m(0, 1, AW'(4 * i), 0, 4'hF, 0);
            step();
        end
        set_m(0, 0, 15'h0000, 0, 4'h0, 0); step(); step();

        // Reset while m1 requests, then contention must go to m0
        set_m(0, 1, 15'h0040, 0, 4'hF, 0); step();
        set_m(0, 0, 15'h0000, 0, 4'h0, 0);
        set_m(1, 1, 15'h0044, 0, 4'hF, 0);
        rst = 1'b1; step(); rst = 1'b0;
        set_m(0, 1, 15'h0048, 0, 4'hF, 0); step();
        set_m(0, 0, 15'h0000, 0, 4'h0, 0); step();
        set_m(1, 0, 15'h0000, 0, 4'h0, 0); step(); step();

        // Random traffic; a master left waiting keeps its request unchanged
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!(req[m] && !granted[m])) begin
                    set_m(m, $urandom_range(0, 99) < 60, AW'($urandom_range(0, 63) * 4),
                          $urandom_range(0, 1) == 1, BW'($urandom), $urandom);
                end
            end
            step();
        end
        set_m(0, 0, 15'h0000, 0, 4'h0, 0);
        set_m(1, 0, 15'h0000, 0, 4'h0, 0);
        step(); step(); step();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
